// File: rtl/vec_normalize.sv
// vec_normalize: scales a complex 2-element column to unit norm (x*10^8/norm_in)
// using one shared restoring divider that produces one quotient bit per cycle.
module vec_normalize #(
  parameter int     QW    = 16,
  parameter longint SCALE = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [27:0] real_1,
  input  logic signed [27:0] imag_1,
  input  logic signed [27:0] real_2,
  input  logic signed [27:0] imag_2,
  input  logic signed [55:0] norm_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [27:0] q_real_1,
  output logic signed [27:0] q_imag_1,
  output logic signed [27:0] q_real_2,
  output logic signed [27:0] q_imag_2,
  output logic               div_zero,
  output logic               sat
);
  localparam int CW = $clog2(QW);
  typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, DONE} state_t;
  state_t             st_q, st_d;
  logic [1:0]         k_q, k_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [55:0]        rem_q, rem_d;
  logic [55+QW:0]     den_q, den_d;
  logic [QW-1:0]      quo_q, quo_d;
  logic signed [55:0] norm_q, norm_d;
  logic signed [27:0] x_q [4];
  logic signed [27:0] x_d [4];
  logic signed [27:0] qo_q [4];
  logic signed [27:0] qo_d [4];
  logic               dz_q, dz_d, sat_q, sat_d;
  logic signed [27:0] xk, mag, qv;
  logic [27:0]        ax;
  logic [55:0]        prod;
  logic               sat_k, ge, accept;
  assign accept    = in_valid & in_ready;
  assign in_ready  = (st_q == IDLE) & ~rst;
  assign out_valid = st_q == DONE;
  assign xk    = x_q[k_q];
  assign ax    = xk[27] ? 28'(-xk) : 28'(xk);
  assign prod  = 56'(ax) * 56'(SCALE);
  // Quotient would not fit in QW bits: clamp instead of dividing
  assign sat_k = {{QW{1'b0}}, prod} >= {norm_q, {QW{1'b0}}};
  assign ge    = {{QW{1'b0}}, rem_q} >= den_q;
  assign mag   = 28'(quo_q);
  assign qv    = xk[27] ? -mag : mag;
  assign q_real_1 = qo_q[0];
  assign q_imag_1 = qo_q[1];
  assign q_real_2 = qo_q[2];
  assign q_imag_2 = qo_q[3];
  assign div_zero = dz_q;
  assign sat      = sat_q;
  always_comb begin
    st_d   = st_q;
    k_d    = k_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    norm_d = norm_q;
    x_d    = x_q;
    qo_d   = qo_q;
    dz_d   = dz_q;
    sat_d  = sat_q;
    case (st_q)
      IDLE: if (accept) begin
        x_d[0] = real_1;
        x_d[1] = imag_1;
        x_d[2] = real_2;
        x_d[3] = imag_2;
        norm_d = norm_in;
        sat_d  = 1'b0;
        k_d    = 2'd0;
        dz_d   = norm_in[55] || norm_in == '0;
        st_d   = dz_d ? DONE : LOAD;
        if (dz_d) qo_d = '{default: '0};
      end
      LOAD: begin
        rem_d = prod;
        den_d = {{QW{1'b0}}, norm_q} << (QW - 1);
        cnt_d = CW'(QW - 1);
        quo_d = sat_k ? '1 : '0;
        sat_d = sat_q | sat_k;
        st_d  = sat_k ? STORE : DIV;
      end
      DIV: begin
        rem_d = ge ? rem_q - den_q[55:0] : rem_q;
        quo_d = {quo_q[QW-2:0], ge};
        den_d = den_q >> 1;
        cnt_d = cnt_q - 1'b1;
        st_d  = cnt_q == '0 ? STORE : DIV;
      end
      STORE: begin
        qo_d[k_q] = qv;
        k_d  = k_q + 2'd1;
        st_d = k_q == 2'd3 ? DONE : LOAD;
      end
      DONE: st_d = out_ready ? IDLE : DONE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      k_q    <= '0;
      cnt_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      norm_q <= '0;
      x_q    <= '{default: '0};
      qo_q   <= '{default: '0};
      dz_q   <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      k_q    <= k_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      norm_q <= norm_d;
      x_q    <= x_d;
      qo_q   <= qo_d;
      dz_q   <= dz_d;
      sat_q  <= sat_d;
    end
  end
endmodule

// File: tb/tb_vec_normalize.sv
// tb_vec_normalize: directed vector table with hand-computed quotients,
// plus backpressure and mid-division reset sequences.
module tb_vec_normalize;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0, out_ready = 1'b0;
  logic               in_ready, out_valid, div_zero, sat;
  logic signed [27:0] real_1 = '0, imag_1 = '0, real_2 = '0, imag_2 = '0;
  logic signed [55:0] norm_in = '0;
  logic signed [27:0] q_real_1, q_imag_1, q_real_2, q_imag_2;
  int errs = 0, nchk = 0;

  typedef struct {
    longint x0, x1, x2, x3, norm;
    longint q0, q1, q2, q3;
    logic   dz, st;
    int     lat;
  } vec_t;
  vec_t tv [8];

  vec_normalize dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .real_1(real_1), .imag_1(imag_1), .real_2(real_2), .imag_2(imag_2),
    .norm_in(norm_in), .out_valid(out_valid), .out_ready(out_ready),
    .q_real_1(q_real_1), .q_imag_1(q_imag_1), .q_real_2(q_real_2), .q_imag_2(q_imag_2),
    .div_zero(div_zero), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_q(input string n, input vec_t v);
    chk({n, " q_real_1"}, q_real_1, v.q0);
    chk({n, " q_imag_1"}, q_imag_1, v.q1);
    chk({n, " q_real_2"}, q_real_2, v.q2);
    chk({n, " q_imag_2"}, q_imag_2, v.q3);
    chk({n, " div_zero"}, div_zero, v.dz);
    chk({n, " sat"}, sat, v.st);
  endtask

  // Accept edge is E0; lat counts edges after E0 until out_valid is seen
  task automatic accept_col(input vec_t v);
    @(negedge clk);
    real_1 = 28'(v.x0); imag_1 = 28'(v.x1); real_2 = 28'(v.x2); imag_2 = 28'(v.x3);
    norm_in = 56'(v.norm);
    in_valid = 1'b1;
    chk("in_ready before accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_col(input string n, input vec_t v, input int hold);
    int lat;
    accept_col(v);
    lat = 0;
    while (!out_valid && lat < 200) begin
      chk({n, " in_ready busy"}, in_ready, 0);
      @(posedge clk);
      #1 lat++;
    end
    chk({n, " latency"}, lat, v.lat);
    chk_q(n, v);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      chk({n, " hold out_valid"}, out_valid, 1);
      chk({n, " hold in_ready"}, in_ready, 0);
      chk({n, " hold q_real_1"}, q_real_1, v.q0);
      chk({n, " hold q_imag_1"}, q_imag_1, v.q1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({n, " out_valid after ack"}, out_valid, 0);
    chk({n, " in_ready after ack"}, in_ready, 1);
  endtask

  initial begin
    tv[0] = '{3, 4, 0, 0, 50000, 6000, 8000, 0, 0, 1'b0, 1'b0, 72};
    tv[1] = '{-30000, 0, 0, 40000, 500000000, -6000, 0, 0, 8000, 1'b0, 1'b0, 72};
    tv[2] = '{1, 1, 1, 0, 17320, 5773, 5773, 5773, 0, 1'b0, 1'b0, 72};
    tv[3] = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0};
    tv[4] = '{10000, 0, 0, 0, 1, 65535, 0, 0, 0, 1'b0, 1'b1, 56};
    tv[5] = '{-7, 0, 5, 0, 30000, -23333, 0, 16666, 0, 1'b0, 1'b0, 72};
    tv[6] = '{2, -2, 0, 0, -100, 0, 0, 0, 0, 1'b1, 1'b0, 0};
    tv[7] = '{0, -10000, 0, 0, 1, 0, -65535, 0, 0, 1'b0, 1'b1, 56};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk_q("reset", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("in_ready after reset", in_ready, 1);

    for (int i = 0; i < 8; i++)
      run_col($sformatf("vec%0d", i), tv[i], i == 0 ? 10 : 0);

    // Reset 20 cycles into the first column's processing
    accept_col(tv[0]);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst in_ready", in_ready, 0);
    chk("midrst out_valid", out_valid, 0);
    chk_q("midrst", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("midrst in_ready released", in_ready, 1);
    begin
      int seen = 0;
      repeat (80) begin
        @(posedge clk);
        #1 seen |= int'(out_valid);
      end
      chk("midrst out_valid never rises", seen, 0);
      chk("midrst q_real_1 stays zero", q_real_1, 0);
    end
    run_col("after midrst", tv[2], 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
